// File: rtl/sparce_skip_ctrl_pkg.sv
// Shared types and default widths for the SparCE skip controller.
package sparce_pkg;
  localparam int PC_W_DEF  = 32;
  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    WAIT     = 2'd2,
    REDIRECT = 2'd3
  } skip_state_t;
endpackage

// File: rtl/sparce_skip_ctrl_if.sv
// Lookup-candidate and fetch-redirect handshakes of the SparCE skip controller.
interface sparce_skip_ctrl_if
  import sparce_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int REG_W = REG_W_DEF
);
  logic             lookup_valid;
  logic             lookup_ready;
  logic [PC_W-1:0]  lookup_pc;
  logic [PC_W-1:0]  lookup_target;
  logic [REG_W-1:0] lookup_rs;
  logic             skip_valid;
  logic             skip_ready;
  logic [PC_W-1:0]  skip_target;

  // master: SASA lookup source and fetch sink; slave: the controller
  modport master (
    output lookup_valid, lookup_pc, lookup_target, lookup_rs, skip_ready,
    input  lookup_ready, skip_valid, skip_target
  );
  modport slave (
    input  lookup_valid, lookup_pc, lookup_target, lookup_rs, skip_ready,
    output lookup_ready, skip_valid, skip_target
  );
endinterface

// File: rtl/sparce_skip_ctrl_sat_counter.sv
// Saturating event counter used for the skip/abort statistics; holds at all-ones.
module sparce_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1'b1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/sparce_skip_ctrl.sv
// SparCE skip sequencer: checks the condition register's sparsity, waits out writebacks,
// then redirects fetch. Statistics counters are built only when SPARCE_SKIP_STATS_EN is defined.
module sparce_skip_ctrl
  import sparce_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int HAZ_TIMEOUT = 8,
  parameter int CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sparce_skip_ctrl_if.slave  if_bus,
  output logic [REG_W-1:0]   o_srf_rs,
  input  logic               i_srf_sparse,
  input  logic               i_wb_pending,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_stat_skips,
  output logic [CNT_W-1:0]   o_stat_aborts
);
  localparam int TMR_W = $clog2(HAZ_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HAZ_TIMEOUT - 1);

  skip_state_t      r_state;
  logic [REG_W-1:0] r_srf_rs;
  logic [PC_W-1:0]  r_target;
  logic [TMR_W-1:0] r_timer;

  logic             w_accept;
  logic             w_forward;
  logic [PC_W:0]    w_pc_plus4;

  assign w_accept   = if_bus.lookup_valid && if_bus.lookup_ready;
  // One extra bit so the +4 never wraps and a short hop is always discarded
  assign w_pc_plus4 = {1'b0, if_bus.lookup_pc} + (PC_W + 1)'(32'd4);
  assign w_forward  = ({1'b0, if_bus.lookup_target} > w_pc_plus4);

  // Candidate sequencing FSM with registered SRF address, redirect target and hazard timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_srf_rs <= '0;
      r_target <= '0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_srf_rs <= if_bus.lookup_rs;
            r_target <= if_bus.lookup_target;
            r_state  <= w_forward ? CHECK : IDLE;
          end
        end
        CHECK: begin
          r_timer <= '0;
          if (i_flush)           r_state <= IDLE;
          else if (i_wb_pending) r_state <= WAIT;
          else if (i_srf_sparse) r_state <= REDIRECT;
          else                   r_state <= IDLE;
        end
        WAIT: begin
          r_timer <= r_timer + TMR_W'(1'b1);
          if (i_flush)                  r_state <= IDLE;
          else if (!i_wb_pending)       r_state <= CHECK;
          else if (r_timer == TMR_LAST) r_state <= IDLE;
          else                          r_state <= WAIT;
        end
        REDIRECT: begin
          // flush wins over a same-cycle skip_ready
          if (i_flush || if_bus.skip_ready) r_state <= IDLE;
          else                              r_state <= REDIRECT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_bus.lookup_ready = (r_state == IDLE) && !i_flush;
  assign if_bus.skip_valid   = (r_state == REDIRECT) && !i_flush;
  assign if_bus.skip_target  = r_target;
  assign o_srf_rs            = r_srf_rs;

`ifdef SPARCE_SKIP_STATS_EN
  logic w_skip_inc;
  logic w_abort_inc;

  assign w_skip_inc  = (r_state == REDIRECT) && if_bus.skip_ready && !i_flush;
  assign w_abort_inc = ((r_state != IDLE) && i_flush) ||
                       ((r_state == WAIT) && i_wb_pending && (r_timer == TMR_LAST));

  sparce_sat_counter #(.CNT_W(CNT_W)) u_cnt_skips (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_skip_inc),
    .o_count (o_stat_skips)
  );

  sparce_sat_counter #(.CNT_W(CNT_W)) u_cnt_aborts (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_abort_inc),
    .o_count (o_stat_aborts)
  );
`else
  assign o_stat_skips  = '0;
  assign o_stat_aborts = '0;
`endif
endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// Directed self-checking bench for sparce_skip_ctrl (HAZ_TIMEOUT=8).
module tb_sparce_skip_ctrl;
  localparam int PC_W  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;
`ifdef SPARCE_SKIP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] srf_rs;
  logic             srf_sparse;
  logic             wb_pending;
  logic             flush;
  logic [CNT_W-1:0] stat_skips;
  logic [CNT_W-1:0] stat_aborts;

  int total;
  int bad;
  int exp_skips;
  int exp_aborts;

  sparce_skip_ctrl_if #(.PC_W(PC_W), .REG_W(REG_W)) bus ();

  sparce_skip_ctrl #(
    .PC_W(PC_W), .REG_W(REG_W), .HAZ_TIMEOUT(8), .CNT_W(CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .if_bus        (bus.slave),
    .o_srf_rs      (srf_rs),
    .i_srf_sparse  (srf_sparse),
    .i_wb_pending  (wb_pending),
    .i_flush       (flush),
    .o_stat_skips  (stat_skips),
    .o_stat_aborts (stat_aborts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] stat_exp(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  task automatic chk_stats(input string tag);
    chk({tag, "_skips"}, 64'(stat_skips), stat_exp(exp_skips));
    chk({tag, "_aborts"}, 64'(stat_aborts), stat_exp(exp_aborts));
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] tgt, input logic [4:0] rs);
    bus.lookup_valid  = 1'b1;
    bus.lookup_pc     = pc;
    bus.lookup_target = tgt;
    bus.lookup_rs     = rs;
  endtask

  initial begin
    total = 0; bad = 0; exp_skips = 0; exp_aborts = 0;
    rst = 1'b1; srf_sparse = 1'b0; wb_pending = 1'b0; flush = 1'b0;
    bus.lookup_valid = 1'b0; bus.lookup_pc = '0; bus.lookup_target = '0;
    bus.lookup_rs = '0; bus.skip_ready = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_ready", 64'(bus.lookup_ready), 64'd1);
    chk("rst_svalid", 64'(bus.skip_valid), 64'd0);
    chk("rst_srf_rs", 64'(srf_rs), 64'd0);
    chk("rst_target", 64'(bus.skip_target), 64'd0);
    chk_stats("rst");
    rst = 1'b0;
    tick();

    // 1: sparse, no hazard -> redirect at N+2
    srf_sparse = 1'b1; bus.skip_ready = 1'b1;
    offer(32'h100, 32'h120, 5'd5);
    #1 chk("t1_ready_n", 64'(bus.lookup_ready), 64'd1);
    tick(); bus.lookup_valid = 1'b0;
    chk("t1_ready_n1", 64'(bus.lookup_ready), 64'd0);
    chk("t1_srf_rs", 64'(srf_rs), 64'd5);
    chk("t1_svalid_n1", 64'(bus.skip_valid), 64'd0);
    tick();
    chk("t1_svalid_n2", 64'(bus.skip_valid), 64'd1);
    chk("t1_target", 64'(bus.skip_target), 64'h120);
    tick(); exp_skips = 1;
    chk("t1_svalid_n3", 64'(bus.skip_valid), 64'd0);
    chk("t1_ready_n3", 64'(bus.lookup_ready), 64'd1);
    chk_stats("t1");

    // 2: not sparse -> back to IDLE at N+2, no counts
    srf_sparse = 1'b0;
    offer(32'h200, 32'h240, 5'd3);
    tick(); bus.lookup_valid = 1'b0;
    chk("t2_ready_n1", 64'(bus.lookup_ready), 64'd0);
    tick();
    chk("t2_ready_n2", 64'(bus.lookup_ready), 64'd1);
    chk("t2_svalid_n2", 64'(bus.skip_valid), 64'd0);
    chk_stats("t2");

    // 3: writeback pending N+1..N+3 -> redirect at N+6
    srf_sparse = 1'b1;
    offer(32'h300, 32'h380, 5'd9);
    tick(); bus.lookup_valid = 1'b0; wb_pending = 1'b1;
    tick(); tick(); tick(); wb_pending = 1'b0;
    chk("t3_svalid_n4", 64'(bus.skip_valid), 64'd0);
    tick();
    chk("t3_svalid_n5", 64'(bus.skip_valid), 64'd0);
    tick();
    chk("t3_svalid_n6", 64'(bus.skip_valid), 64'd1);
    chk("t3_target", 64'(bus.skip_target), 64'h380);
    tick(); exp_skips = 2;
    chk("t3_ready_n7", 64'(bus.lookup_ready), 64'd1);
    chk_stats("t3");

    // 4: writeback stuck -> abandon after 8 WAIT cycles (IDLE at N+10)
    offer(32'h400, 32'h480, 5'd1);
    tick(); bus.lookup_valid = 1'b0; wb_pending = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("t4_ready_wait", 64'(bus.lookup_ready), 64'd0);
      chk("t4_svalid_wait", 64'(bus.skip_valid), 64'd0);
    end
    tick(); exp_aborts = 1;
    chk("t4_ready_n10", 64'(bus.lookup_ready), 64'd1);
    chk("t4_svalid_n10", 64'(bus.skip_valid), 64'd0);
    chk_stats("t4");
    wb_pending = 1'b0;

    // 5: redirect stalled 4 cycles, then flush with skip_ready
    bus.skip_ready = 1'b0;
    offer(32'h500, 32'h5a0, 5'd7);
    tick(); bus.lookup_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_valid", 64'(bus.skip_valid), 64'd1);
      chk("t5_hold_target", 64'(bus.skip_target), 64'h5a0);
      if (i < 3) tick();
    end
    flush = 1'b1; bus.skip_ready = 1'b1;
    #1 chk("t5_flush_gate", 64'(bus.skip_valid), 64'd0);
    tick(); exp_aborts = 2;
    chk("t5_ready_flush", 64'(bus.lookup_ready), 64'd0);
    flush = 1'b0;
    #1 chk("t5_ready_idle", 64'(bus.lookup_ready), 64'd1);
    chk_stats("t5");

    // 6: target == pc+4 discarded, pc+5 accepted; flush in IDLE blocks accept
    offer(32'h100, 32'h104, 5'd6);
    tick(); bus.lookup_valid = 1'b0;
    chk("t6_disc_ready", 64'(bus.lookup_ready), 64'd1);
    chk("t6_disc_rs", 64'(srf_rs), 64'd6);
    srf_sparse = 1'b0;
    offer(32'h100, 32'h105, 5'd2);
    tick(); bus.lookup_valid = 1'b0;
    chk("t6_edge_ready", 64'(bus.lookup_ready), 64'd0);
    tick();
    flush = 1'b1;
    offer(32'h600, 32'h700, 5'd11);
    #1 chk("t6_flush_ready", 64'(bus.lookup_ready), 64'd0);
    tick(); bus.lookup_valid = 1'b0; flush = 1'b0;
    #1 chk("t6_flush_idle", 64'(bus.lookup_ready), 64'd1);
    chk("t6_flush_rs", 64'(srf_rs), 64'd2);
    chk_stats("t6");

    // 7: reset pulse during redirect
    srf_sparse = 1'b1; bus.skip_ready = 1'b0;
    offer(32'h800, 32'h8c0, 5'd13);
    tick(); bus.lookup_valid = 1'b0;
    tick();
    chk("t7_svalid_pre", 64'(bus.skip_valid), 64'd1);
    #2 rst = 1'b1;
    #1 chk("t7_svalid_rst", 64'(bus.skip_valid), 64'd0);
    exp_skips = 0; exp_aborts = 0;
    chk("t7_target_rst", 64'(bus.skip_target), 64'd0);
    chk("t7_rs_rst", 64'(srf_rs), 64'd0);
    chk_stats("t7");
    tick(); rst = 1'b0;
    tick();
    chk("t7_svalid_post", 64'(bus.skip_valid), 64'd0);
    chk("t7_ready_post", 64'(bus.lookup_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
